dmem_arbiter: RTL and testbench

Shares the 4-bank, byte-lane data memory between two requesters: the execute stage's single-word load/store port (CPU) and a burst loader (DMA) used for program/data preload and dump. Round-robin arbitration at access boundaries; DMA bursts are non-preemptible. Drives the memory's active-low lane enables (`0` = write lane) and returns registered read data one cycle after each access.

---
 rtl/dmem_pkg.sv | 16 +
 rtl/dmem_arbiter.sv | 131 +++++++++++++
 tb/tb_dmem_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter and its memory wrapper.
// Lane enables are active-low: a 0 bit writes that byte lane.
package dmem_pkg;

  localparam int AW = 8;
  localparam int LW = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam logic [3:0] WREN_NONE = 4'b1111;
  localparam logic [3:0] WREN_ALL  = 4'b0000;

endpackage

// File: rtl/dmem_arbiter.sv
// Round-robin CPU/DMA arbiter for the 4-bank byte-lane data memory; CPU grant is same-cycle, read data +1.
// Requesters hold req until granted; a DMA burst owns the memory until its last beat, CPU waits meanwhile.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int AW = dmem_pkg::AW,
  parameter int LW = dmem_pkg::LW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic [3:0]    cpu_wren_n,
  input  logic [AW-1:0] cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [31:0]   cpu_rdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [LW-1:0] dma_len,
  input  logic [31:0]   dma_wdata,
  output logic          dma_gnt,
  output logic          dma_wready,
  output logic          dma_rvalid,
  output logic [31:0]   dma_rdata,
  output logic          dma_done,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_wren_n,
  input  logic [31:0]   mem_rdata
);

  state_t        state;
  state_t        state_nxt;
  logic          last_dma;
  logic [LW-1:0] beat;
  logic [LW-1:0] b_len;
  logic [AW-1:0] b_addr;
  logic          b_we;
  logic          cpu_win;
  logic          dma_win;
  logic          beat_last;
  logic          cpu_rd;
  logic          dma_rd;

  // Outputs are forced to their idle values while rst_n is low so an
  // aborted burst cannot write one more beat at the reset edge.
  always_comb begin
    state_nxt  = state;
    cpu_gnt    = 1'b0;
    dma_gnt    = 1'b0;
    dma_wready = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_wren_n = WREN_NONE;
    beat_last  = 1'b0;
    cpu_win    = cpu_req && (!dma_req || last_dma);
    dma_win    = dma_req && !cpu_win;
    if (rst_n) begin
      case (state)
        IDLE: begin
          if (cpu_win) begin
            cpu_gnt    = 1'b1;
            mem_addr   = cpu_addr;
            mem_wdata  = cpu_wdata;
            mem_wren_n = cpu_wren_n;
          end else if (dma_win) begin
            dma_gnt   = 1'b1;
            state_nxt = BURST;
          end
        end
        BURST: begin
          mem_addr   = b_addr + AW'(beat);
          mem_wdata  = dma_wdata;
          mem_wren_n = b_we ? WREN_ALL : WREN_NONE;
          dma_wready = b_we;
          beat_last  = (beat == b_len);
          if (beat_last) begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign cpu_rd = cpu_gnt && (cpu_wren_n == WREN_NONE);
  assign dma_rd = rst_n && (state == BURST) && !b_we;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_dma   <= 1'b1;
      beat       <= '0;
      b_len      <= '0;
      b_addr     <= '0;
      b_we       <= 1'b0;
      cpu_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      dma_rvalid <= 1'b0;
      dma_rdata  <= '0;
      dma_done   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (cpu_gnt) begin
        last_dma <= 1'b0;
      end else if (dma_gnt) begin
        last_dma <= 1'b1;
      end
      if (dma_gnt) begin
        b_addr <= dma_addr;
        b_len  <= dma_len;
        b_we   <= dma_we;
        beat   <= '0;
      end else if (state == BURST) begin
        beat <= beat + 1'b1;
      end
      cpu_rvalid <= cpu_rd;
      if (cpu_rd) begin
        cpu_rdata <= mem_rdata;
      end
      dma_rvalid <= dma_rd;
      if (dma_rd) begin
        dma_rdata <= mem_rdata;
      end
      dma_done <= (state == BURST) && beat_last;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: table of CPU accesses, hand-written burst/reset/tie sequences,
// and random mixed traffic checked against a word-level memory image and arbitration rules.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req;
  logic [3:0]  cpu_wren_n;
  logic [7:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_gnt;
  logic        cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        dma_req;
  logic        dma_we;
  logic [7:0]  dma_addr;
  logic [3:0]  dma_len;
  logic [31:0] dma_wdata;
  logic        dma_gnt;
  logic        dma_wready;
  logic        dma_rvalid;
  logic [31:0] dma_rdata;
  logic        dma_done;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wren_n;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_wren_n(cpu_wren_n), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_len(dma_len),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_wready(dma_wready),
    .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata), .dma_done(dma_done),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren_n(mem_wren_n), .mem_rdata(mem_rdata)
  );

  // Four byte-lane banks outside the arbiter; ref_mem is the expected image.
  logic [31:0] tb_mem  [256];
  logic [31:0] ref_mem [256];
  logic        init_mem = 1'b0;
  int          cyc = 0;

  assign mem_rdata = tb_mem[mem_addr];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (init_mem) begin
      for (int i = 0; i < 256; i++) tb_mem[i] <= ref_mem[i];
    end else begin
      for (int k = 0; k < 4; k++)
        if (!mem_wren_n[k]) tb_mem[mem_addr][8*k +: 8] <= mem_wdata[8*k +: 8];
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] wn);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++)
      if (!wn[k]) r[8*k +: 8] = d[8*k +: 8];
    return r;
  endfunction

  // Starts and ends just after a rising edge.
  task automatic cpu_access(input logic [3:0] wn, input logic [7:0] a, input logic [31:0] d,
                            output logic [31:0] got, output int gcyc);
    int n;
    logic [31:0] exp;
    got = '0;
    gcyc = -1;
    cpu_req = 1'b1; cpu_wren_n = wn; cpu_addr = a; cpu_wdata = d;
    n = 0;
    @(negedge clk);
    while (!cpu_gnt && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("cpu_gnt", 32'(cpu_gnt), 32'd1);
    if (!cpu_gnt) begin
      cpu_req = 1'b0;
      @(posedge clk); #1;
      return;
    end
    check("cpu_wait_le17", 32'(n <= 17), 32'd1);
    gcyc = cyc;
    check("cpu_mem_addr", 32'(mem_addr), 32'(a));
    check("cpu_mem_wren", 32'(mem_wren_n), 32'(wn));
    exp = ref_mem[a];
    if (wn != WREN_NONE) begin
      check("cpu_mem_wdata", mem_wdata, d);
      ref_mem[a] = merge(exp, d, wn);
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
    if (wn == WREN_NONE) begin
      @(negedge clk);
      check("cpu_rvalid", 32'(cpu_rvalid), 32'd1);
      check("cpu_rdata", cpu_rdata, exp);
      got = cpu_rdata;
      @(posedge clk); #1;
    end
  endtask

  task automatic dma_burst(input logic we, input logic [7:0] a, input logic [3:0] len,
                           input logic [31:0] base, output int gcyc);
    int n;
    int lenv;
    logic [7:0]  ba;
    logic [31:0] prev;
    lenv = int'(len);
    gcyc = -1;
    prev = '0;
    dma_req = 1'b1; dma_we = we; dma_addr = a; dma_len = len; dma_wdata = base;
    n = 0;
    @(negedge clk);
    while (!dma_gnt && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("dma_gnt", 32'(dma_gnt), 32'd1);
    if (!dma_gnt) begin
      dma_req = 1'b0;
      @(posedge clk); #1;
      return;
    end
    gcyc = cyc;
    check("dma_gnt_no_access", 32'(mem_wren_n), 32'(WREN_NONE));
    @(posedge clk); #1;
    dma_req = 1'b0;
    for (int k = 0; k <= lenv; k++) begin
      ba = a + 8'(k);
      @(negedge clk);
      check("dma_beat_addr", 32'(mem_addr), 32'(ba));
      check("dma_beat_wren", 32'(mem_wren_n), we ? 32'(WREN_ALL) : 32'(WREN_NONE));
      check("dma_wready", 32'(dma_wready), 32'(we));
      check("cpu_gnt_in_burst", 32'(cpu_gnt), 32'd0);
      check("dma_done_early", 32'(dma_done), 32'd0);
      if (we) begin
        check("dma_beat_wdata", mem_wdata, base + 32'(k));
        ref_mem[ba] = base + 32'(k);
      end else begin
        check("dma_rvalid", 32'(dma_rvalid), 32'(k != 0));
        if (k != 0) check("dma_rdata", dma_rdata, prev);
        prev = ref_mem[ba];
      end
      @(posedge clk); #1;
      dma_wdata = base + 32'(k) + 32'd1;
    end
    @(negedge clk);
    check("dma_done", 32'(dma_done), 32'd1);
    check("dma_done_cycle", 32'(cyc - gcyc), 32'(lenv + 2));
    if (!we) begin
      check("dma_rvalid_last", 32'(dma_rvalid), 32'd1);
      check("dma_rdata_last", dma_rdata, prev);
    end
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [3:0]  wren_n;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t        tbl [10];
  logic [31:0] got_a, got_b;
  int          ca, cb, da;
  int          mism;

  initial begin
    tbl[0] = '{4'b0000, 8'h05, 32'h11223344, 32'h0};
    tbl[1] = '{4'b1100, 8'h05, 32'hAABBCCDD, 32'h0};
    tbl[2] = '{4'b1111, 8'h05, 32'h0,        32'h1122CCDD};
    tbl[3] = '{4'b0000, 8'h09, 32'hDEADBEEF, 32'h0};
    tbl[4] = '{4'b1001, 8'h09, 32'h00555500, 32'h0};
    tbl[5] = '{4'b1111, 8'h09, 32'h0,        32'hDE5555EF};
    tbl[6] = '{4'b0000, 8'hFF, 32'h0F0F0F0F, 32'h0};
    tbl[7] = '{4'b0111, 8'hFF, 32'hF0000000, 32'h0};
    tbl[8] = '{4'b1111, 8'hFF, 32'h0,        32'hF00F0F0F};
    tbl[9] = '{4'b1111, 8'h05, 32'h0,        32'h1122CCDD};

    rst_n = 1'b0;
    cpu_req = 1'b0; cpu_wren_n = WREN_NONE; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_len = '0; dma_wdata = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = $urandom;
    init_mem = 1'b1;
    @(posedge clk); #1;
    init_mem = 1'b0;
    @(posedge clk); #1;

    // reset state
    @(negedge clk);
    check("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
    check("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    check("rst_cpu_rdata", cpu_rdata, 32'd0);
    check("rst_dma_gnt", 32'(dma_gnt), 32'd0);
    check("rst_dma_rvalid", 32'(dma_rvalid), 32'd0);
    check("rst_dma_done", 32'(dma_done), 32'd0);
    check("rst_dma_wready", 32'(dma_wready), 32'd0);
    check("rst_mem_wren", 32'(mem_wren_n), 32'(WREN_NONE));
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_mem_wren", 32'(mem_wren_n), 32'(WREN_NONE));
    @(posedge clk); #1;

    // tie out of reset: CPU, then DMA, then CPU after the burst
    fork
      begin
        cpu_access(4'b0000, 8'h20, 32'h12345678, got_a, ca);
        cpu_access(WREN_NONE, 8'h20, 32'h0, got_b, cb);
      end
      dma_burst(1'b0, 8'h30, 4'd2, 32'h0, da);
    join
    check("tie_dma_after_cpu", 32'(da), 32'(ca + 1));
    check("tie_cpu_after_burst", 32'(cb), 32'(da + 4));
    check("tie_readback", got_b, 32'h12345678);

    // table of CPU accesses
    for (int i = 0; i < 10; i++) begin
      cpu_access(tbl[i].wren_n, tbl[i].addr, tbl[i].wdata, got_a, ca);
      if (tbl[i].wren_n == WREN_NONE) check("tbl_rdata", got_a, tbl[i].exp);
    end

    // wrapping DMA write burst, then DMA read of the wrapped words
    dma_burst(1'b1, 8'hFE, 4'd3, 32'd1, da);
    check("wrap_mem_fe", tb_mem[8'hFE], 32'd1);
    check("wrap_mem_ff", tb_mem[8'hFF], 32'd2);
    check("wrap_mem_00", tb_mem[8'h00], 32'd3);
    check("wrap_mem_01", tb_mem[8'h01], 32'd4);
    dma_burst(1'b0, 8'h00, 4'd1, 32'h0, da);

    // reset in beat 2 of a 16-beat write
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 8'h40; dma_len = 4'hF; dma_wdata = 32'd100;
    @(negedge clk);
    check("abort_gnt", 32'(dma_gnt), 32'd1);
    @(posedge clk); #1;
    dma_req = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("abort_beat_addr", 32'(mem_addr), 32'(8'h40 + 8'(k)));
      ref_mem[8'h40 + 8'(k)] = 32'd100 + 32'(k);
      @(posedge clk); #1;
      dma_wdata = 32'd101 + 32'(k);
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_wren_now", 32'(mem_wren_n), 32'(WREN_NONE));
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("abort_no_done", 32'(dma_done), 32'd0);
      check("abort_wren_after", 32'(mem_wren_n), 32'(WREN_NONE));
      @(posedge clk); #1;
    end
    check("abort_mem_beat0", tb_mem[8'h40], 32'd100);
    check("abort_mem_beat1", tb_mem[8'h41], 32'd101);
    check("abort_mem_beat2", tb_mem[8'h42], ref_mem[8'h42]);

    // back-to-back CPU reads of 0..7
    for (int i = 0; i <= 8; i++) begin
      cpu_req = (i < 8); cpu_wren_n = WREN_NONE; cpu_addr = 8'(i); cpu_wdata = '0;
      @(negedge clk);
      if (i < 8) check("b2b_gnt", 32'(cpu_gnt), 32'd1);
      if (i > 0) begin
        check("b2b_rvalid", 32'(cpu_rvalid), 32'd1);
        check("b2b_rdata", cpu_rdata, ref_mem[i-1]);
      end
      @(posedge clk); #1;
    end

    // random mixed traffic
    for (int it = 0; it < 30; it++) begin
      logic [3:0]  wn;
      logic [7:0]  a;
      logic        we;
      logic [7:0]  da_addr;
      logic [3:0]  len;
      logic [31:0] d;
      int sel;
      sel = $urandom_range(0, 2);
      wn = ($urandom_range(0, 1) == 1) ? WREN_NONE : 4'($urandom);
      a = 8'($urandom);
      d = $urandom;
      we = 1'($urandom);
      da_addr = 8'($urandom);
      len = 4'($urandom);
      if (sel == 0) begin
        cpu_access(wn, a, d, got_a, ca);
      end else if (sel == 1) begin
        dma_burst(we, da_addr, len, d, da);
      end else begin
        fork
          cpu_access(wn, a, d ^ 32'h5A5A5A5A, got_a, ca);
          dma_burst(we, da_addr, len, d, da);
        join
        check("rand_cpu_not_in_burst",
              32'((ca < da) || (ca >= da + int'(len) + 2)), 32'd1);
      end
    end

    mism = 0;
    for (int i = 0; i < 256; i++)
      if (tb_mem[i] !== ref_mem[i]) mism++;
    check("final_mem_image", 32'(mism), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
